// File: rtl/nfca_rx_pkg.sv
// NFC-A 106 kbps reader receive path: shared constants and state type.
package nfca_rx_pkg;

  localparam int SAMPLES_PER_WIN = 16;
  localparam int WINS_PER_HALF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    SOF2,
    DATA
  } rx_state_e;

endpackage

// File: rtl/nfca_rx_p2p.sv
// Per-window (16 samples) peak-to-peak tracker of the antenna envelope.
module nfca_rx_p2p
  import nfca_rx_pkg::*;
#(
  parameter int ADC_W = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             realign,
  input  logic             en,
  input  logic [ADC_W-1:0] data,
  output logic             win_done,
  output logic [ADC_W-1:0] p2p
);

  logic [3:0]       cnt_q, cnt_d;
  logic [ADC_W-1:0] max_q, max_d;
  logic [ADC_W-1:0] min_q, min_d;
  logic [ADC_W-1:0] cur_max, cur_min;
  logic             first;

  always_comb begin
    first   = (cnt_q == '0);
    cur_max = (first || data > max_q) ? data : max_q;
    cur_min = (first || data < min_q) ? data : min_q;
    // cur_max >= cur_min always, so the difference never wraps
    p2p      = cur_max - cur_min;
    win_done = en && (cnt_q == 4'(SAMPLES_PER_WIN - 1));
    cnt_d = cnt_q;
    max_d = max_q;
    min_d = min_q;
    if (realign) begin
      cnt_d = '0;
      max_d = '0;
      min_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 4'd1;
      max_d = cur_max;
      min_d = cur_min;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      max_q <= '0;
      min_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      min_q <= min_d;
    end
  end

endmodule

// File: rtl/nfca_rx_demodulate.sv
// NFC-A reader RX: subcarrier detect, SOF/Manchester decode, EOF/collision.
// Optional adaptive threshold: NFCA_RX_AUTO_THRESHOLD_EN.
module nfca_rx_demodulate
  import nfca_rx_pkg::*;
#(
  parameter int ADC_W  = 12,
  parameter int THRESH = 64,
  parameter int MAJ    = 2
) (
  input  logic             rstn,
  input  logic             clk,
  input  logic             rx_window,
  input  logic             adc_data_en,
  input  logic [ADC_W-1:0] adc_data,
  output logic             rx_on,
  output logic             rx_bit_en,
  output logic             rx_bit,
  output logic             rx_end,
  output logic             rx_error
);

  localparam logic [ADC_W-1:0] THR_C = ADC_W'(THRESH);
  localparam logic [2:0]       MAJ_C = 3'(MAJ);
  localparam logic [1:0]       WLAST = 2'(WINS_PER_HALF - 1);

  logic             win_done;
  logic [ADC_W-1:0] p2p;
  logic [ADC_W-1:0] thr;
  logic             win_mod;

  rx_state_e  state_q, state_d;
  logic [1:0] widx_q, widx_d;
  logic       half_q, half_d;
  logic [2:0] cnt_q, cnt_d;
  logic       h1_q, h1_d;
  logic       on_q, on_d;
  logic       bit_en_q, bit_en_d;
  logic       bit_q, bit_d;
  logic       end_q, end_d;
  logic       err_q, err_d;
  logic [2:0] acc;
  logic       hmod;

  nfca_rx_p2p #(
    .ADC_W(ADC_W)
  ) u_p2p (
    .clk     (clk),
    .rstn    (rstn),
    .realign (~rx_window),
    .en      (adc_data_en),
    .data    (adc_data),
    .win_done(win_done),
    .p2p     (p2p)
  );

  assign win_mod = (p2p >= thr);

`ifdef NFCA_RX_AUTO_THRESHOLD_EN
  logic [ADC_W-1:0] nf_q, nf_d;
  logic [ADC_W:0]   nf2;

  always_comb begin
    nf2 = {nf_q, 1'b0};
    thr = nf2[ADC_W] ? '1 : nf2[ADC_W-1:0];
    if (thr < THR_C) thr = THR_C;
    nf_d = nf_q;
    if (rx_window && state_q == IDLE && win_done && !win_mod)
      nf_d = nf_q - (nf_q >> 3) + (p2p >> 3);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) nf_q <= '0;
    else       nf_q <= nf_d;
  end
`else
  assign thr = THR_C;
`endif

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    half_d   = half_q;
    cnt_d    = cnt_q;
    h1_d     = h1_q;
    on_d     = on_q;
    bit_en_d = 1'b0;
    bit_d    = bit_q;
    end_d    = 1'b0;
    err_d    = err_q;
    acc      = cnt_q + {2'b00, win_mod};
    hmod     = (acc >= MAJ_C);
    if (!rx_window) begin
      state_d = IDLE;
      widx_d  = '0;
      half_d  = 1'b0;
      cnt_d   = '0;
      h1_d    = 1'b0;
      on_d    = 1'b0;
      if (on_q) begin
        end_d = 1'b1;
        err_d = 1'b1;
      end
    end else if (win_done) begin
      unique case (state_q)
        IDLE: begin
          // this hit is window 0 of the SOF first half
          if (win_mod) begin
            state_d = SOF2;
            widx_d  = 2'd1;
            half_d  = 1'b0;
            cnt_d   = 3'd1;
            h1_d    = 1'b0;
          end
        end
        SOF2, DATA: begin
          widx_d = widx_q + 2'd1;
          cnt_d  = acc;
          if (widx_q == WLAST) begin
            cnt_d = '0;
            if (!half_q) begin
              half_d = 1'b1;
              h1_d   = hmod;
            end else begin
              half_d = 1'b0;
              if (state_q == SOF2) begin
                if (h1_q && !hmod) begin
                  state_d = DATA;
                  on_d    = 1'b1;
                end else begin
                  state_d = IDLE;
                end
              end else begin
                unique case (1'b1)
                  (h1_q && !hmod): begin
                    bit_en_d = 1'b1;
                    bit_d    = 1'b1;
                  end
                  (!h1_q && hmod): begin
                    bit_en_d = 1'b1;
                    bit_d    = 1'b0;
                  end
                  (!h1_q && !hmod): begin
                    end_d   = 1'b1;
                    err_d   = 1'b0;
                    on_d    = 1'b0;
                    state_d = IDLE;
                  end
                  (h1_q && hmod): begin
                    end_d   = 1'b1;
                    err_d   = 1'b1;
                    on_d    = 1'b0;
                    state_d = IDLE;
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      widx_q   <= '0;
      half_q   <= 1'b0;
      cnt_q    <= '0;
      h1_q     <= 1'b0;
      on_q     <= 1'b0;
      bit_en_q <= 1'b0;
      bit_q    <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      half_q   <= half_d;
      cnt_q    <= cnt_d;
      h1_q     <= h1_d;
      on_q     <= on_d;
      bit_en_q <= bit_en_d;
      bit_q    <= bit_d;
      end_q    <= end_d;
      err_q    <= err_d;
    end
  end

  assign rx_on     = on_q;
  assign rx_bit_en = bit_en_q;
  assign rx_bit    = bit_q;
  assign rx_end    = end_q;
  assign rx_error  = err_q;

endmodule

// File: tb/tb_nfca_rx_demodulate.sv
// Directed bench for nfca_rx_demodulate (default build, THRESH=64, MAJ=2).
module tb_nfca_rx_demodulate;

  localparam logic [11:0] BASE = 12'd1000;

  logic        rstn;
  logic        clk;
  logic        rx_window;
  logic        adc_data_en;
  logic [11:0] adc_data;
  logic        rx_on;
  logic        rx_bit_en;
  logic        rx_bit;
  logic        rx_end;
  logic        rx_error;

  int n_chk  = 0;
  int n_fail = 0;
  int smp_cnt = 0;
  int n_bit_en = 0;
  int n_end = 0;
  int n_on = 0;
  int bit_smp[$];
  int end_smp[$];

  logic o_bit_en, o_bit, o_end, o_err, o_on;

  nfca_rx_demodulate #(
    .ADC_W (12),
    .THRESH(64),
    .MAJ   (2)
  ) dut (
    .rstn       (rstn),
    .clk        (clk),
    .rx_window  (rx_window),
    .adc_data_en(adc_data_en),
    .adc_data   (adc_data),
    .rx_on      (rx_on),
    .rx_bit_en  (rx_bit_en),
    .rx_bit     (rx_bit),
    .rx_end     (rx_end),
    .rx_error   (rx_error)
  );

  initial clk = 1'b0;
  always #6 clk = ~clk;

  always @(negedge clk) begin
    if (rx_bit_en) begin
      n_bit_en++;
      bit_smp.push_back(smp_cnt);
    end
    if (rx_end) begin
      n_end++;
      end_smp.push_back(smp_cnt);
    end
    if (rx_on) n_on++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic smp(input logic [11:0] d);
    @(negedge clk);
    adc_data_en = 1'b1;
    adc_data    = d;
    smp_cnt++;
    @(negedge clk);
    adc_data_en = 1'b0;
    o_bit_en = rx_bit_en;
    o_bit    = rx_bit;
    o_end    = rx_end;
    o_err    = rx_error;
    o_on     = rx_on;
    repeat (4) @(negedge clk);
  endtask

  task automatic win(input int p);
    for (int i = 0; i < 16; i++)
      smp((i == 1) ? BASE + 12'(p) : BASE);
  endtask

  task automatic half4(input int a, input int b,
                       input int c, input int d);
    win(a);
    win(b);
    win(c);
    win(d);
  endtask

  task automatic bitp(input int a, input int b);
    half4(a, a, a, a);
    half4(b, b, b, b);
  endtask

  task automatic sof();
    bitp(200, 20);
    chk("sof_on", o_on, 1);
    chk("sof_nobit", o_bit_en, 0);
  endtask

  task automatic dbit(input string tag, input int a,
                      input int b, input int e);
    bitp(a, b);
    chk({tag, "_en"}, o_bit_en, 1);
    chk({tag, "_val"}, o_bit, e);
    chk({tag, "_noend"}, o_end, 0);
  endtask

  int b0, e0, nb0, ne0, no0;

  initial begin
    rstn        = 1'b0;
    rx_window   = 1'b1;
    adc_data_en = 1'b0;
    adc_data    = '0;
    repeat (3) @(negedge clk);
    chk("rst_on", rx_on, 0);
    chk("rst_bit_en", rx_bit_en, 0);
    chk("rst_bit", rx_bit, 0);
    chk("rst_end", rx_end, 0);
    chk("rst_err", rx_error, 0);
    rstn = 1'b1;

    // idle noise below threshold
    nb0 = n_bit_en; ne0 = n_end; no0 = n_on;
    for (int w = 0; w < 625; w++) win(20);
    chk("idle_bit_en", n_bit_en - nb0, 0);
    chk("idle_end", n_end - ne0, 0);
    chk("idle_on", n_on - no0, 0);

    // frame: SOF 1 0 0 1 EOF
    b0 = bit_smp.size();
    e0 = end_smp.size();
    sof();
    dbit("f1_b0", 200, 20, 1);
    dbit("f1_b1", 20, 200, 0);
    dbit("f1_b2", 20, 200, 0);
    dbit("f1_b3", 200, 20, 1);
    bitp(20, 20);
    chk("f1_end", o_end, 1);
    chk("f1_err", o_err, 0);
    chk("f1_on", o_on, 0);
    chk("f1_bit_hold", o_bit, 1);
    chk("f1_nbits", bit_smp.size() - b0, 4);
    chk("f1_nend", end_smp.size() - e0, 1);
    if (bit_smp.size() - b0 == 4 && end_smp.size() - e0 == 1) begin
      for (int k = 0; k < 3; k++)
        chk("f1_gap", bit_smp[b0+k+1] - bit_smp[b0+k], 128);
      chk("f1_eof_gap", end_smp[e0] - bit_smp[b0+3], 128);
    end
    win(20);
    win(20);

    // SOF with both halves modulated is dropped silently
    ne0 = n_end;
    bitp(200, 200);
    chk("badsof_on", o_on, 0);
    chk("badsof_end", n_end - ne0, 0);
    win(20);

    // collision
    sof();
    dbit("col_b0", 200, 20, 1);
    bitp(200, 200);
    chk("col_end", o_end, 1);
    chk("col_err", o_err, 1);
    chk("col_on", o_on, 0);
    chk("col_nobit", o_bit_en, 0);
    win(20);

    // majority boundary 64 vs 63
    sof();
    half4(64, 64, 63, 63);
    half4(63, 63, 63, 63);
    chk("maj_b1_en", o_bit_en, 1);
    chk("maj_b1_val", o_bit, 1);
    half4(63, 63, 63, 63);
    half4(63, 64, 63, 64);
    chk("maj_b0_en", o_bit_en, 1);
    chk("maj_b0_val", o_bit, 0);
    half4(64, 63, 63, 63);
    half4(63, 63, 63, 64);
    chk("maj_eof_end", o_end, 1);
    chk("maj_eof_err", o_err, 0);
    win(20);

    // abort coinciding with the 128th sample of a bit
    sof();
    dbit("ab_b0", 20, 200, 0);
    nb0 = n_bit_en;
    half4(200, 200, 200, 200);
    win(20);
    win(20);
    win(20);
    for (int i = 0; i < 15; i++)
      smp((i == 1) ? BASE + 12'd20 : BASE);
    @(negedge clk);
    adc_data_en = 1'b1;
    adc_data    = BASE;
    rx_window   = 1'b0;
    smp_cnt++;
    @(negedge clk);
    adc_data_en = 1'b0;
    chk("ab_end", rx_end, 1);
    chk("ab_err", rx_error, 1);
    chk("ab_on", rx_on, 0);
    chk("ab_nobit", rx_bit_en, 0);
    @(negedge clk);
    chk("ab_end_pulse", rx_end, 0);
    repeat (3) @(negedge clk);
    rx_window = 1'b1;
    chk("ab_bitcnt", n_bit_en - nb0, 0);

    // recovery frame
    win(20);
    sof();
    dbit("rc_b0", 20, 200, 0);
    dbit("rc_b1", 200, 20, 1);
    bitp(20, 20);
    chk("rc_end", o_end, 1);
    chk("rc_err", o_err, 0);

    // async reset mid-frame: no rx_end
    win(20);
    sof();
    ne0 = n_end;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_on", rx_on, 0);
    chk("rst_mid_end", rx_end, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_nend", n_end - ne0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
